// File: rtl/mesh_term_injector_pkg.sv
// mesh_pkg: shared mesh packet geometry, packet layout and stall FSM states.
// Default packet widths, the packed packet layout (row in the MSBs, payload in
// the LSBs) and the state encoding of the injector's stall watchdog.
package mesh_pkg;
  localparam int PCKG_SZ = 32;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int PAY_W = PCKG_SZ - ROW_W - COL_W - 1;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
    logic [PAY_W-1:0] payload;
  } mesh_pkt_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALLED} stall_st_e;
endpackage

// File: rtl/mesh_term_injector_fifo.sv
// mesh_sync_fifo: DEPTH x W synchronous FIFO with a registered head word.
// Ports: clk, reset (sync, active-high); push_i/pop_i are already-qualified
// (the caller never pushes when full or pops when empty); wdata_i is the word
// to write; head_o is the registered oldest entry (0 when empty); count_o is
// the occupancy; full_o/empty_o decode the registered count.
module mesh_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  // The head register is loaded with whatever will be oldest after this edge:
  // the word being written when nothing older survives, otherwise the stored
  // entry at the advanced read pointer.
  always_comb begin
    rd_d    = rd_q + AW'(pop_i);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    head_d  = (count_d == '0) ? '0 : (count_q == CW'(pop_i)) ? wdata_i : mem_q[rd_d];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push_i);
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= wdata_i;
  assign head_o  = head_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/mesh_term_injector.sv
// mesh_term_injector: terminal-side injection stage feeding one mesh router input.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with in_row, in_col,
// in_mode, in_payload form the producer request; pndng/data_out/pop form the
// router-input handshake; count is FIFO occupancy; sent_cnt counts accepted
// pops (saturating); err_pop flags a pop with nothing pending; err_stall flags
// a head word left pending TIMEOUT cycles. Both error flags are sticky.
module mesh_term_injector #(
  parameter int PCKG_SZ = mesh_pkg::PCKG_SZ,
  parameter int DEPTH   = 8,
  parameter int ROW_W   = mesh_pkg::ROW_W,
  parameter int COL_W   = mesh_pkg::COL_W,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROW_W-1:0]               in_row,
  input  logic [COL_W-1:0]               in_col,
  input  logic                           in_mode,
  input  logic [PCKG_SZ-ROW_W-COL_W-2:0] in_payload,
  output logic                           pndng,
  output logic [PCKG_SZ-1:0]             data_out,
  input  logic                           pop,
  output logic [$clog2(DEPTH):0]         count,
  output logic [CNT_W-1:0]               sent_cnt,
  output logic                           err_pop,
  output logic                           err_stall
);
  import mesh_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  logic          full, empty, push, pop_ok, remain;
  stall_st_e     state_q;
  logic [TW-1:0] tmr_q;
  // in_ready comes only from the registered count, so a pop never frees a
  // slot for a push in the same cycle.
  assign in_ready = !full;
  assign push     = in_valid & !full;
  assign pndng    = !empty;
  assign pop_ok   = pop & !empty;
  assign remain   = (count > CW'(1)) | push;
  mesh_sync_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop_ok),
    .wdata_i ({in_row, in_col, in_mode, in_payload}),
    .head_o  (data_out),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
  // The state tracks pndng for the coming cycle: WAIT is entered on the edge
  // that makes a word pending, so the timer counts whole pending cycles and
  // reaches TIMEOUT-1 at the end of the TIMEOUT-th one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      sent_cnt  <= '0;
      err_pop   <= 1'b0;
      err_stall <= 1'b0;
    end else begin
      err_pop <= err_pop | (pop & empty);
      if (pop_ok && sent_cnt != '1) sent_cnt <= sent_cnt + CNT_W'(1);
      if (pop_ok) begin
        state_q <= remain ? ST_WAIT : ST_IDLE;
        tmr_q   <= '0;
      end else if (state_q == ST_IDLE && push) begin
        state_q <= ST_WAIT;
        tmr_q   <= '0;
      end else if (state_q == ST_WAIT) begin
        if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_q   <= ST_STALLED;
          err_stall <= 1'b1;
        end else begin
          tmr_q <= tmr_q + TW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mesh_term_injector.sv
// tb_mesh_term_injector: scoreboard bench for mesh_term_injector.
module tb_mesh_term_injector;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_row = '0;
  logic [3:0]  in_col = '0;
  logic        in_mode = 1'b0;
  logic [22:0] in_payload = '0;
  logic        pndng;
  logic [31:0] data_out;
  logic        pop = 1'b0;
  logic [3:0]  count;
  logic [15:0] sent_cnt;
  logic        err_pop;
  logic        err_stall;
  int          checks = 0;
  int          failures = 0;
  int          mcnt = 0;
  int          msent = 0;
  logic [31:0] exp_q [$];

  mesh_term_injector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col), .in_mode(in_mode), .in_payload(in_payload),
    .pndng(pndng), .data_out(data_out), .pop(pop), .count(count),
    .sent_cnt(sent_cnt), .err_pop(err_pop), .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle the presented head must equal the scoreboard front;
  // an accepted pop retires that entry.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (pndng) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL head: data_out=%h presented but scoreboard is empty", data_out);
        end else if (data_out !== exp_q[0]) begin
          failures++;
          $display("FAIL head: data_out=%h expected %h", data_out, exp_q[0]);
        end
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (data_out !== 32'h0) begin
        failures++;
        $display("FAIL idle_data: data_out=%h expected 0 while pndng=0", data_out);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic p, input logic [3:0] r, input logic [3:0] c,
                     input logic m, input logic [22:0] pl);
    bit acc_push, acc_pop;
    in_valid = v; pop = p; in_row = r; in_col = c; in_mode = m; in_payload = pl;
    acc_push = v && (mcnt < 8);
    acc_pop  = p && (mcnt > 0);
    if (acc_push) exp_q.push_back({r, c, m, pl});
    mcnt = mcnt + int'(acc_push) - int'(acc_pop);
    if (acc_pop) msent++;
    @(posedge clk); #1;
    in_valid = 1'b0; pop = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_pndng", pndng, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_err_pop", err_pop, 0);
    chk("rst_err_stall", err_stall, 0);
    // single packet round trip
    cyc(1, 0, 4'd2, 4'd3, 1'b0, 23'h1234);
    chk("t1_pndng", pndng, 1);
    chk("t1_data", data_out, 32'h2300_1234);
    chk("t1_count", count, 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t1_pndng_after_pop", pndng, 0);
    chk("t1_sent", sent_cnt, 1);
    // fill to full
    for (int i = 0; i < 8; i++) cyc(1, 0, 4'(i), 4'(7 - i), i[0], 23'(i * 'h111 + 5));
    chk("full_count", count, 8);
    chk("full_ready", in_ready, 0);
    // push rejected at full even with a simultaneous pop
    cyc(1, 1, 4'hF, 4'hF, 1'b1, 23'h7FFFFF);
    chk("fullpop_count", count, 7);
    chk("fullpop_ready", in_ready, 1);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("drain_pndng", pndng, 0);
    chk("drain_count", count, 0);
    chk("drain_sent", sent_cnt, 32'(msent));
    // push and pop together
    cyc(1, 0, 4'd1, 4'd1, 1'b0, 23'h11);
    cyc(1, 1, 4'd5, 4'd6, 1'b1, 23'h22);
    chk("pp_count", count, 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("pp_count_after", count, 0);
    chk("pp_sent", sent_cnt, 32'(msent));
    // stall watchdog
    cyc(1, 0, 4'd9, 4'd10, 1'b1, 23'h3ABCDE);
    repeat (1023) cyc(0, 0, 0, 0, 0, 0);
    chk("stall_before", err_stall, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_at_1024", err_stall, 1);
    chk("stall_pndng", pndng, 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("stall_pop_pndng", pndng, 0);
    chk("stall_sticky", err_stall, 1);
    chk("stall_sent", sent_cnt, 32'(msent));
    // pop while empty
    chk("errpop_before", err_pop, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("errpop_set", err_pop, 1);
    chk("errpop_count", count, 0);
    chk("errpop_sent", sent_cnt, 32'(msent));
    // reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1, 0, 4'(i + 3), 4'(i), 1'b0, 23'(i + 'h40));
    chk("pre_rst_count", count, 5);
    reset = 1'b1;
    exp_q.delete();
    mcnt = 0;
    msent = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_pndng", pndng, 0);
    chk("mid_rst_sent", sent_cnt, 0);
    chk("mid_rst_err_pop", err_pop, 0);
    chk("mid_rst_err_stall", err_stall, 0);
    chk("mid_rst_ready", in_ready, 1);
    // operation after reset
    cyc(1, 0, 4'hA, 4'h5, 1'b1, 23'h0055AA);
    chk("post_rst_data", data_out, 32'hA5_8055AA);
    cyc(0, 1, 0, 0, 0, 0);
    chk("post_rst_sent", sent_cnt, 1);
    chk("post_rst_empty", pndng, 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
